// File: rtl/blink_if.sv
`default_nettype none
// ============================================================================
//  Module   : blink_if
//  Brief    : Request / blinker handshake bundle for blink_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface blink_if;
   logic req_error;
   logic req_success;
   logic done_blinking;
   logic start_blinking;
   logic blinkType;
   logic busy;
   logic dropped;
   logic timeout;

   // master: lock controller plus blinker side; slave: the sequencer itself
   modport master (
      output req_error, req_success, done_blinking,
      input  start_blinking, blinkType, busy, dropped, timeout
   );
   modport slave (
      input  req_error, req_success, done_blinking,
      output start_blinking, blinkType, busy, dropped, timeout
   );
endinterface
`default_nettype wire

// File: rtl/blink_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : blink_sequencer
//  Brief    : Arbitrates error/success blink requests into a one-deep slot and
//             sequences the blinker with an enforced LED-off gap.
//             Optional watchdog on the RUN phase: BLINK_WATCHDOG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module blink_sequencer #(
   parameter logic [23:0] GAP_CYCLES  = 24'd1200000,
   parameter logic [7:0]  ACK_CYCLES  = 8'd16,
   parameter logic [31:0] WDOG_CYCLES = 32'd48000000
) (
   input  wire logic hwclk,
   input  wire logic reset,
   blink_if.slave    bif
);

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_START    = 3'd1;
   localparam logic [2:0] c_WAIT_ACK = 3'd2;
   localparam logic [2:0] c_RUN      = 3'd3;
   localparam logic [2:0] c_GAP      = 3'd4;

   localparam logic [23:0] c_GAP_LAST = (GAP_CYCLES == 24'd0) ? 24'd0 : GAP_CYCLES - 24'd1;
   localparam logic [7:0]  c_ACK_LAST = (ACK_CYCLES == 8'd0)  ? 8'd0  : ACK_CYCLES - 8'd1;

   logic [2:0]  r_state;
   logic        r_slot_vld;
   logic        r_slot_type;
   logic        r_start;
   logic        r_type;
   logic [7:0]  r_ack;
   logic [23:0] r_gap;

   logic w_launch;
   logic w_eff_vld;
   logic w_next_vld;
   logic w_next_type;
   logic w_drop;
   logic w_timeout;

   // A launch frees the slot in the same cycle, so capture sees it empty.
   assign w_launch  = (r_state == c_IDLE) && r_slot_vld && bif.done_blinking;
   assign w_eff_vld = r_slot_vld && !w_launch;

   always_comb begin
      w_next_vld  = w_eff_vld;
      w_next_type = r_slot_type;
      w_drop      = 1'b0;
      if (bif.req_error) begin
         w_next_vld  = 1'b1;
         w_next_type = 1'b0;
         w_drop      = bif.req_success || w_eff_vld;
      end else if (bif.req_success) begin
         if (w_eff_vld) begin
            w_drop = 1'b1;
         end else begin
            w_next_vld  = 1'b1;
            w_next_type = 1'b1;
         end
      end
   end

`ifdef BLINK_WATCHDOG_EN
   localparam logic [31:0] c_WDOG_LAST = (WDOG_CYCLES == 32'd0) ? 32'd0 : WDOG_CYCLES - 32'd1;
   logic [31:0] r_wdog;

   assign w_timeout = (r_state == c_RUN) && !bif.done_blinking && (r_wdog >= c_WDOG_LAST);

   // Cleared while waiting for the ack so RUN always starts counting from zero.
   always_ff @(posedge hwclk) begin
      if (reset) begin
         r_wdog <= 32'd0;
      end else if (r_state == c_WAIT_ACK) begin
         r_wdog <= 32'd0;
      end else if ((r_state == c_RUN) && (r_wdog != 32'hFFFF_FFFF)) begin
         r_wdog <= r_wdog + 32'd1;
      end
   end
`else
   logic w_unused_wdog;
   assign w_unused_wdog = ^WDOG_CYCLES;
   assign w_timeout     = 1'b0;
`endif

   always_ff @(posedge hwclk) begin
      if (reset) begin
         r_state     <= c_IDLE;
         r_slot_vld  <= 1'b0;
         r_slot_type <= 1'b0;
         r_start     <= 1'b0;
         r_type      <= 1'b0;
         r_ack       <= 8'd0;
         r_gap       <= 24'd0;
      end else begin
         r_slot_vld  <= w_next_vld;
         r_slot_type <= w_next_type;
         r_start     <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_launch) begin
                  r_state <= c_START;
                  r_type  <= r_slot_type;
                  r_start <= 1'b1;
               end
            end
            c_START: begin
               r_state <= c_WAIT_ACK;
               r_ack   <= 8'd0;
            end
            c_WAIT_ACK: begin
               if (!bif.done_blinking) begin
                  r_state <= c_RUN;
               end else if (r_ack >= c_ACK_LAST) begin
                  r_state <= c_GAP;
                  r_gap   <= 24'd0;
               end else begin
                  r_ack <= r_ack + 8'd1;
               end
            end
            c_RUN: begin
               if (bif.done_blinking || w_timeout) begin
                  r_state <= c_GAP;
                  r_gap   <= 24'd0;
               end
            end
            c_GAP: begin
               if (r_gap >= c_GAP_LAST) begin
                  r_state <= c_IDLE;
               end else begin
                  r_gap <= r_gap + 24'd1;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign bif.start_blinking = r_start;
   assign bif.blinkType      = r_type;
   assign bif.busy           = !((r_state == c_IDLE) && !r_slot_vld);
   assign bif.dropped        = w_drop && !reset;
   assign bif.timeout        = w_timeout && !reset;

endmodule
`default_nettype wire

// File: tb/tb_blink_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blink_sequencer
//  Brief    : Directed plus random stimulus against an event-time reference
//             model of blink_sequencer, with a simple blinker model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_blink_sequencer;

   localparam int GAP_N  = 4;
   localparam int ACK_N  = 3;
   localparam int WDOG_N = 20;
   localparam int NEVER  = 1 << 30;
`ifdef BLINK_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   localparam int MODE_NORMAL = 0;
   localparam int MODE_IGNORE = 1;
   localparam int MODE_STUCK  = 2;

   logic hwclk = 1'b0;
   logic reset;
   blink_if bif ();

   blink_sequencer #(
      .GAP_CYCLES  (24'(GAP_N)),
      .ACK_CYCLES  (8'(ACK_N)),
      .WDOG_CYCLES (32'(WDOG_N))
   ) dut (
      .hwclk (hwclk),
      .reset (reset),
      .bif   (bif)
   );

   always #5 hwclk = ~hwclk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // blinker: done is low for cycles lo_from..lo_to
   int lo_from = -1;
   int lo_to   = -2;
   int bl_mode = MODE_NORMAL;
   int bl_n    = 3;

   // reference model: pending slot (-1 empty, 0 error, 1 success) and event times
   int m_slot     = -1;
   int m_idle_at  = 0;
   int m_start_at = -1;
   int m_tout_at  = -1;
   bit m_type     = 1'b0;
   int m_mode     = MODE_NORMAL;
   int m_n        = 1;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick(input bit re, input bit rs, input bit rst_in);
      bit done_now, launch, e_start, e_busy, e_drop, e_tout;
      int eff, s, gap_start, n_eff;
      done_now          = !(cyc >= lo_from && cyc <= lo_to);
      bif.req_error     = re;
      bif.req_success   = rs;
      bif.done_blinking = done_now;
      reset             = rst_in;
      if (rst_in) begin
         m_slot     = -1;
         m_idle_at  = cyc + 1;
         m_start_at = -1;
         m_tout_at  = -1;
         m_type     = 1'b0;
         @(negedge hwclk);
      end else begin
         launch  = (cyc >= m_idle_at) && (m_slot >= 0) && done_now;
         e_start = (cyc == m_start_at);
         e_tout  = (cyc == m_tout_at);
         e_busy  = (cyc < m_idle_at) || (m_slot >= 0);
         eff     = launch ? -1 : m_slot;
         e_drop  = 1'b0;
         if (re) begin
            e_drop = rs || (eff >= 0);
            eff    = 0;
         end else if (rs) begin
            if (eff >= 0) e_drop = 1'b1;
            else          eff    = 1;
         end
         @(negedge hwclk);
         chk("start_blinking", bif.start_blinking, e_start);
         chk("blinkType",      bif.blinkType,      m_type);
         chk("busy",           bif.busy,           e_busy);
         chk("dropped",        bif.dropped,        e_drop);
         chk("timeout",        bif.timeout,        e_tout);
         if (launch) begin
            s          = cyc + 1;
            m_start_at = s;
            m_mode     = bl_mode;
            m_n        = bl_n;
            m_tout_at  = -1;
            m_type     = (m_slot == 1);
            if (m_mode == MODE_IGNORE) begin
               gap_start = s + 1 + ACK_N;
            end else begin
               n_eff = (m_mode == MODE_STUCK) ? NEVER : m_n;
               if (WD && n_eff >= WDOG_N + 1) begin
                  m_tout_at = s + 1 + WDOG_N;
                  gap_start = s + 2 + WDOG_N;
               end else if (m_mode == MODE_STUCK) begin
                  gap_start = NEVER;
               end else begin
                  gap_start = s + 2 + n_eff;
               end
            end
            m_idle_at = (gap_start == NEVER) ? NEVER : gap_start + GAP_N;
         end
         m_slot = eff;
         if (cyc == m_start_at && m_mode != MODE_IGNORE) begin
            lo_from = cyc + 1;
            lo_to   = (m_mode == MODE_STUCK) ? NEVER : cyc + m_n;
         end
      end
      @(posedge hwclk);
      #1;
      cyc++;
   endtask

   // Blinker finally raises done; an unbounded RUN then ends on this cycle.
   task automatic release_done();
      lo_to = cyc - 1;
      if (m_idle_at == NEVER) m_idle_at = cyc + 1 + GAP_N;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int r;
      reset             = 1'b1;
      bif.req_error     = 1'b0;
      bif.req_success   = 1'b0;
      bif.done_blinking = 1'b1;
      @(posedge hwclk);
      #1;
      cyc = 0;

      // reset state, then a single success request at cycle 10
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
      while (cyc < 10) tick(1'b0, 1'b0, 1'b0);
      bl_mode = MODE_NORMAL;
      bl_n    = 5;
      tick(1'b0, 1'b1, 1'b0);
      idle(20);

      // simultaneous error + success while idle
      tick(1'b1, 1'b1, 1'b0);
      idle(25);

      // error displaces a queued success during a success RUN
      bl_n = 8;
      tick(1'b0, 1'b1, 1'b0);
      idle(4);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      idle(40);

      // blinker ignores start: ack timeout, then the queued request goes out
      bl_mode = MODE_IGNORE;
      tick(1'b0, 1'b1, 1'b0);
      idle(2);
      tick(1'b1, 1'b0, 1'b0);
      bl_mode = MODE_NORMAL;
      bl_n    = 2;
      idle(30);

      // blinker holds done low: watchdog abort, or RUN held until release
      bl_mode = MODE_STUCK;
      tick(1'b1, 1'b0, 1'b0);
      idle(35);
      bl_mode = MODE_NORMAL;
      release_done();
      idle(12);

      // reset in the middle of RUN with the slot full
      bl_n = 15;
      tick(1'b0, 1'b1, 1'b0);
      idle(5);
      tick(1'b1, 1'b0, 1'b0);
      idle(1);
      tick(1'b0, 1'b0, 1'b1);
      lo_to = NEVER;
      idle(1);
      tick(1'b0, 1'b1, 1'b0);
      idle(5);
      release_done();
      idle(30);

      // randomized traffic
      for (int b = 0; b < 6; b++) begin
         bl_mode = ($urandom_range(0, 4) == 0) ? MODE_IGNORE : MODE_NORMAL;
         bl_n    = $urandom_range(1, 8);
         for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 15);
            tick((r == 0) || (r == 1), (r == 1) || (r == 2) || (r == 3), 1'b0);
         end
      end
      idle(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
